// File: rtl/reset_sequencer.sv
// reset_sequencer: gathers power-up/input reset, a filtered asynchronous
// external request and a software pulse. It holds every reset domain for
// CYCLES clocks after the last event, then releases the domains one by one,
// STAGE_GAP clocks apart. It also reports the last cause and keeps a
// saturating event count.
module reset_sequencer #(
    parameter int CYCLES        = 20,
    parameter int CHANNELS      = 3,
    parameter int STAGE_GAP     = 4,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ext_rst_req,
    input  logic                sw_rst_req,
    output logic [CHANNELS-1:0] reset_o,
    output logic                ready,
    output logic [1:0]          cause,
    output logic [7:0]          rst_count
);

    // The hold counter runs from 0 up to RUN_AT and then stops.
    // Reaching RUN_AT puts the FSM in RUN.
    localparam int RUN_AT = CYCLES + (CHANNELS - 1) * STAGE_GAP + 1;
    localparam int CW     = $clog2(RUN_AT + 1);
    localparam int FW     = $clog2(FILTER_CYCLES + 1);

    localparam logic [CW-1:0] RUN_CNT = CW'(RUN_AT);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_CYCLES);

    localparam logic [1:0] CAUSE_RST = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    // A zero or negative parameter gives a meaningless sequence, so elaboration stops.
    if (CYCLES < 1 || CHANNELS < 1 || STAGE_GAP < 1 || FILTER_CYCLES < 1) begin : g_bad_params
        $error("reset_sequencer: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        S_HOLD    = 2'b00,
        S_RELEASE = 2'b01,
        S_RUN     = 2'b10
    } state_t;

    // Every register powers up at its reset value. The sequence therefore
    // runs even when no reset pulse arrives.
    state_t                r_state     = S_HOLD;
    logic [CW-1:0]         r_cnt       = '0;
    logic [CHANNELS-1:0]   r_reset_o   = {CHANNELS{1'b1}};
    logic                  r_ready     = 1'b0;
    logic [1:0]            r_cause     = 2'b00;
    logic [7:0]            r_count     = 8'h00;
    logic                  r_ext_s1    = 1'b0;
    logic                  r_ext_s2    = 1'b0;
    logic [FW-1:0]         r_fcnt      = '0;
    logic                  r_ext_acc_d = 1'b0;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         w_cnt_inc;
    logic [CHANNELS-1:0]   w_reset_o_nxt;
    logic                  w_ready_nxt;
    logic [1:0]            w_cause_nxt;
    logic [7:0]            w_count_nxt;
    logic [7:0]            w_count_inc;
    logic [FW-1:0]         w_fcnt_nxt;
    logic                  w_ext_acc;
    logic                  w_restart;

    // The external request is accepted while the filter stays saturated.
    assign w_ext_acc = (r_fcnt == FLT_MAX);
    assign w_restart = w_ext_acc | sw_rst_req;

    // Filter: count up while the synchronised request is high, and clear it when the request is low.
    always_comb begin
        w_fcnt_nxt = r_fcnt;
        if (r_ext_s2) begin
            if (r_fcnt == FLT_MAX) begin
                w_fcnt_nxt = r_fcnt;
            end else begin
                w_fcnt_nxt = r_fcnt + FW'(1);
            end
        end else begin
            w_fcnt_nxt = '0;
        end
    end

    // Next-state and hold-counter logic. An event restarts HOLD from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = (r_cnt == RUN_CNT) ? r_cnt : (r_cnt + CW'(1));
        if (w_restart) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (int'(w_cnt_inc) >= CYCLES) begin
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_RELEASE: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == RUN_CNT) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_RELEASE;
                    end
                end
                S_RUN: begin
                    w_cnt_nxt   = r_cnt;
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end
            endcase
        end
    end

    // Staged release: channel i drops once the counter reaches CYCLES + i*STAGE_GAP.
    always_comb begin
        w_reset_o_nxt = {CHANNELS{1'b1}};
        for (int i = 0; i < CHANNELS; i++) begin
            w_reset_o_nxt[i] = (int'(w_cnt_nxt) < (CYCLES + i * STAGE_GAP));
        end
        w_ready_nxt = (w_state_nxt == S_RUN);
    end

    // Cause and event count. When events coincide, external wins over software.
    // A held external request is counted only on the cycle it becomes accepted.
    always_comb begin
        w_cause_nxt = r_cause;
        w_count_nxt = r_count;
        w_count_inc = (r_count == 8'hFF) ? r_count : (r_count + 8'd1);
        if (w_ext_acc) begin
            w_cause_nxt = CAUSE_EXT;
            if (!r_ext_acc_d) begin
                w_count_nxt = w_count_inc;
            end else begin
                w_count_nxt = r_count;
            end
        end else if (sw_rst_req) begin
            w_cause_nxt = CAUSE_SW;
            w_count_nxt = w_count_inc;
        end else begin
            w_cause_nxt = r_cause;
            w_count_nxt = r_count;
        end
    end

    // Two-flop synchroniser and filter counter for the asynchronous request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext_s1    <= 1'b0;
            r_ext_s2    <= 1'b0;
            r_fcnt      <= '0;
            r_ext_acc_d <= 1'b0;
        end else begin
            r_ext_s1    <= ext_rst_req;
            r_ext_s2    <= r_ext_s1;
            r_fcnt      <= w_fcnt_nxt;
            r_ext_acc_d <= w_ext_acc;
        end
    end

    // FSM state, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_reset_o <= {CHANNELS{1'b1}};
            r_ready   <= 1'b0;
            r_cause   <= CAUSE_RST;
            r_count   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_reset_o <= w_reset_o_nxt;
            r_ready   <= w_ready_nxt;
            r_cause   <= w_cause_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign reset_o   = r_reset_o;
    assign ready     = r_ready;
    assign cause     = r_cause;
    assign rst_count = r_count;

endmodule
